// File: rtl/vga_line_loader_pkg.sv
// vga_line_loader_pkg: shared display geometry, pixel width and loader state encoding
package vga_line_loader_pkg;
  localparam int H_ACTIVE_DEF = 1024;
  localparam int V_ACTIVE_DEF = 768;
  localparam int PIX_W = 24;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;
endpackage

// File: rtl/vga_line_loader_rd_tracker.sv
// vga_rd_tracker: outstanding-read counter and read/FIFO credit check
module vga_rd_tracker #(
  parameter int MAX_OUTST  = 8,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_accept,
  input  logic        i_rvalid,
  input  logic [11:0] i_wusedw,
  input  logic        i_wreq,
  output logic        o_can_issue,
  output logic        o_idle
);
  localparam int OW = $clog2(MAX_OUTST + 1);
  logic [OW-1:0] r_outst;
  logic          w_rv;
  logic [12:0]   w_fill;
  assign o_idle = r_outst == '0;
  // a return with nothing outstanding was in flight across a reset and is ignored
  assign w_rv = i_rvalid && !o_idle;
  assign w_fill = 13'(i_wusedw) + 13'(r_outst) + 13'(i_wreq);
  assign o_can_issue = (int'(r_outst) < MAX_OUTST) && (int'(w_fill) < FIFO_DEPTH - 1);
  always_ff @(posedge clk) begin
    if (rst) r_outst <= '0;
    else r_outst <= r_outst + OW'(i_accept) - OW'(w_rv);
  end
endmodule

// File: rtl/vga_line_loader.sv
// vga_line_loader: fetches one framebuffer line per load request into the display line FIFO
// LOADER_TEST_PATTERN_EN: write a synthesized pixel pattern instead of reading memory
module vga_line_loader
  import vga_line_loader_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int ADDR_W      = 25,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 1024,
  parameter int FIFO_DEPTH  = 2048,
  parameter int MAX_OUTST   = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOAD_REQ,
  input  logic [12:0]       iLOAD_VLINE,
  input  logic              iCLEAR,
  output logic              oMEM_RD,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  input  logic              iMEM_WAIT,
  input  logic              iMEM_RVALID,
  input  logic [PIX_W-1:0]  iMEM_RDATA,
  output logic              oFIFO_WREQ,
  output logic [PIX_W-1:0]  oFIFO_WDATA,
  input  logic [11:0]       iFIFO_WUSEDW,
  output logic              oFIFO_ACLR,
  output logic              oBUSY,
  output logic              oERR
);
  localparam int PW = $clog2(H_ACTIVE + 1);
  state_t            r_state;
  logic              r_load_d, r_clr_d, r_pend, r_wreq, r_err;
  logic [12:0]       r_pend_vline;
  logic [ADDR_W-1:0] r_base;
  logic [PW-1:0]     r_pix;
  logic [PIX_W-1:0]  r_wdata;
  logic [1:0]        r_aclr;
  logic              w_load_edge, w_clr_edge, w_can, w_idle, w_issue, w_step, w_accept, w_wr;
  logic [PIX_W-1:0]  w_wdata;
  assign w_load_edge = iLOAD_REQ && !r_load_d;
  assign w_clr_edge = iCLEAR && !r_clr_d;
  assign w_issue = r_state == ISSUE && w_can && !w_clr_edge;
`ifdef LOADER_TEST_PATTERN_EN
  logic [7:0] r_vline;
  assign w_accept = 1'b0;
  assign w_step = w_issue;
  assign w_wr = w_issue;
  assign w_wdata = {r_pix[7:0], r_vline, r_pix[7:0] ^ r_vline};
  assign oMEM_RD = 1'b0;
`else
  assign w_accept = w_issue && !iMEM_WAIT;
  assign w_step = w_accept;
  assign w_wr = iMEM_RVALID && !w_idle && !w_clr_edge && (r_state == ISSUE || r_state == DRAIN);
  assign w_wdata = iMEM_RDATA;
  assign oMEM_RD = w_issue;
`endif
  assign oMEM_ADDR = r_base + ADDR_W'(r_pix);
  assign oFIFO_WREQ = r_wreq;
  assign oFIFO_WDATA = r_wdata;
  assign oFIFO_ACLR = |r_aclr;
  assign oBUSY = r_state != IDLE;
  assign oERR = r_err;
  vga_rd_tracker #(.MAX_OUTST(MAX_OUTST), .FIFO_DEPTH(FIFO_DEPTH)) u_trk (
    .clk(iCLK), .rst(iRST), .i_accept(w_accept), .i_rvalid(iMEM_RVALID),
    .i_wusedw(iFIFO_WUSEDW), .i_wreq(r_wreq), .o_can_issue(w_can), .o_idle(w_idle)
  );
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_load_d <= 1'b0;
      r_clr_d <= 1'b0;
      r_pend <= 1'b0;
      r_pend_vline <= '0;
      r_base <= '0;
      r_pix <= '0;
      r_wreq <= 1'b0;
      r_wdata <= '0;
      r_aclr <= '0;
      r_err <= 1'b0;
    end else begin
      r_load_d <= iLOAD_REQ;
      r_clr_d <= iCLEAR;
      r_wreq <= w_wr;
      r_wdata <= w_wdata;
      r_aclr <= {r_aclr[0], w_clr_edge};
      case (r_state)
        IDLE: if (r_pend) begin
          r_pend <= 1'b0;
          r_base <= ADDR_W'(FB_BASE + int'(r_pend_vline) * LINE_STRIDE);
          r_pix <= '0;
`ifdef LOADER_TEST_PATTERN_EN
          r_vline <= r_pend_vline[7:0];
`endif
          r_state <= ISSUE;
        end
        ISSUE: if (w_step) begin
          r_pix <= r_pix + 1'b1;
          if (int'(r_pix) == H_ACTIVE - 1) r_state <= DRAIN;
        end
        DRAIN: if (w_idle && !r_wreq) r_state <= IDLE;
        default: if (w_idle) r_state <= IDLE;
      endcase
      if (w_clr_edge) begin
        r_state <= FLUSH;
        r_pend <= 1'b0;
        r_err <= 1'b0;
      end
      // a clear in the same cycle empties the slot first, so the load still lands
      if (w_load_edge && int'(iLOAD_VLINE) >= V_ACTIVE) r_err <= 1'b1;
      else if (w_load_edge) begin
        r_pend <= 1'b1;
        r_pend_vline <= iLOAD_VLINE;
        if (r_pend && r_state != IDLE && !w_clr_edge) r_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_line_loader.sv
// tb_vga_line_loader: randomized self-checking bench with a memory model and line-content scoreboard
module tb_vga_line_loader;
  localparam int H = 1024, V = 768, AW = 25, BASE = 0, STRIDE = 1024;
`ifdef LOADER_TEST_PATTERN_EN
  localparam int V1 = 3;
  localparam logic [23:0] P0 = 24'h000303, P7 = 24'h070304, PL = 24'hFF03FC;
`else
  localparam int V1 = 5;
  localparam logic [23:0] P0 = 24'd5120, P7 = 24'd5127, PL = 24'd6143;
`endif
  logic clk = 0, rst = 1;
  logic load_req = 0, clear = 0, mem_wait = 0, mem_rvalid = 0;
  logic [12:0] load_vline = 0;
  logic [23:0] mem_rdata = 0;
  logic [11:0] wusedw = 0;
  logic mem_rd, fifo_wreq, fifo_aclr, busy, err;
  logic [AW-1:0] mem_addr;
  logic [23:0] fifo_wdata;
  int asserts = 0, fails = 0;
  int cyc = 0, lat = 2, wait_pct = 0, stall_left = 0, hold_cyc = 0;
  int wr_cnt = 0, wr_bad = 0, acc_cnt = 0, peak_outst = 0, peak_sum = 0, stab_bad = 0, cap_idx = 0;
  int n, wr_snap, v;
  logic [AW-1:0] stall_addr = '1, prev_addr = '0, ra;
  logic prev_stall = 0;
  logic [3:0] aclr_seq;
  logic [23:0] cap [H];
  logic [23:0] exp_q[$];
  int due_q[$];
  logic [AW-1:0] addr_q[$];

  vga_line_loader dut (
    .iCLK(clk), .iRST(rst), .iLOAD_REQ(load_req), .iLOAD_VLINE(load_vline), .iCLEAR(clear),
    .oMEM_RD(mem_rd), .oMEM_ADDR(mem_addr), .iMEM_WAIT(mem_wait), .iMEM_RVALID(mem_rvalid),
    .iMEM_RDATA(mem_rdata), .oFIFO_WREQ(fifo_wreq), .oFIFO_WDATA(fifo_wdata),
    .iFIFO_WUSEDW(wusedw), .oFIFO_ACLR(fifo_aclr), .oBUSY(busy), .oERR(err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_pix(int vl, int k);
`ifdef LOADER_TEST_PATTERN_EN
    logic [7:0] a = 8'(k), b = 8'(vl);
    return {a, b, a ^ b};
`else
    logic [AW-1:0] a = AW'(BASE + vl * STRIDE + k);
    return a[23:0];
`endif
  endfunction

  // memory + FIFO model, evaluated late in each cycle so all inputs are settled
  always @(negedge clk) begin
    #3;
    cyc++;
    if (fifo_wreq) begin
      wr_cnt++;
      if (cap_idx < H) cap[cap_idx] = fifo_wdata;
      cap_idx++;
      if (exp_q.size() == 0 || exp_q[0] !== fifo_wdata) wr_bad++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (prev_stall && (!mem_rd || mem_addr !== prev_addr)) stab_bad++;
    mem_wait = mem_rd && ((stall_left > 0 && mem_addr == stall_addr) || int'($urandom % 100) < wait_pct);
    if (mem_rd && mem_addr == stall_addr) begin
      hold_cyc++;
      if (stall_left > 0) stall_left--;
    end
    prev_stall = mem_rd && mem_wait;
    prev_addr = mem_addr;
    if (mem_rd && !mem_wait) begin
      acc_cnt++;
      due_q.push_back(cyc + lat);
      addr_q.push_back(mem_addr);
      if (addr_q.size() > peak_outst) peak_outst = addr_q.size();
      if (int'(wusedw) + addr_q.size() + int'(fifo_wreq) > peak_sum)
        peak_sum = int'(wusedw) + addr_q.size() + int'(fifo_wreq);
    end
    if (due_q.size() != 0 && due_q[0] <= cyc) begin
      ra = addr_q.pop_front();
      void'(due_q.pop_front());
      mem_rvalid = 1;
      mem_rdata = ra[23:0];
    end else begin
      mem_rvalid = 0;
      mem_rdata = 24'($urandom);
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    asserts++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick(int k = 1);
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic load(int vl, bit push);
    load_vline = 13'(vl);
    load_req = 1;
    if (push) for (int k = 0; k < H; k++) exp_q.push_back(exp_pix(vl, k));
    tick(2);
    load_req = 0;
    tick(1);
  endtask

  task automatic wait_idle(string tag, int budget, int remain);
    int c = 0;
    while (busy && c < budget) begin
      tick(1);
      c++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
    chk({tag, "_writes_left"}, exp_q.size(), remain);
  endtask

  initial begin
    tick(3);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wreq", 32'(fifo_wreq), 0);
    chk("rst_aclr", 32'(fifo_aclr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    tick(1);
    cap_idx = 0;
    acc_cnt = 0;
    load(V1, 1);
    wait_idle("line", 3000, 0);
    chk("line_wr_bad", wr_bad, 0);
    chk("line_pix0", 32'(cap[0]), 32'(P0));
    chk("line_pix7", 32'(cap[7]), 32'(P7));
    chk("line_pixlast", 32'(cap[H-1]), 32'(PL));
    chk("line_wr_count", cap_idx, H);
`ifdef LOADER_TEST_PATTERN_EN
    chk("line_no_reads", acc_cnt, 0);
`else
    chk("line_reads", acc_cnt, H);
    stall_addr = AW'(BASE + 5 * STRIDE + 10);
    stall_left = 3;
    hold_cyc = 0;
    load(5, 1);
    wait_idle("stall", 3000, 0);
    chk("stall_hold", hold_cyc, 4);
    chk("stall_wr_bad", wr_bad, 0);
    stall_addr = '1;
    lat = 10;
    peak_outst = 0;
    load(100, 1);
    wait_idle("outst", 4000, 0);
    chk("outst_peak", peak_outst, 8);
    wusedw = 12'd2040;
    peak_sum = 0;
    load(200, 1);
    wait_idle("gate", 8000, 0);
    chk("gate_peak_sum", peak_sum, 2047);
    chk("gate_wr_bad", wr_bad, 0);
    wusedw = 0;
    load(300, 1);
    n = 0;
    while (addr_q.size() != 6 && n < 100) begin
      tick(1);
      n++;
    end
    chk("clr_outst", addr_q.size(), 6);
    wr_snap = wr_cnt;
    clear = 1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      aclr_seq[i] = fifo_aclr;
    end
    chk("clr_aclr_seq", 32'(aclr_seq), 32'(4'b0011));
    wait_idle("clr", 200, 0);
    chk("clr_returns_done", addr_q.size(), 0);
    chk("clr_no_writes", wr_cnt - wr_snap, 0);
    clear = 0;
    tick(2);
`endif
    acc_cnt = 0;
    load(800, 0);
    tick(2);
    chk("bad_line_err", 32'(err), 1);
    chk("bad_line_busy", 32'(busy), 0);
    chk("bad_line_reads", acc_cnt, 0);
    clear = 1;
    tick(1);
    chk("clr_err", 32'(err), 0);
    clear = 0;
    tick(4);
    lat = 3;
    load(10, 1);
    chk("ovw_busy", 32'(busy), 1);
    load(20, 0);
    chk("ovw_first_err", 32'(err), 0);
    load(30, 1);
    chk("ovw_err", 32'(err), 1);
    wait_idle("ovw_a", 4000, H);
    tick(1);
    wait_idle("ovw_c", 4000, 0);
    chk("ovw_wr_bad", wr_bad, 0);
    clear = 1;
    tick(2);
    clear = 0;
    tick(2);
    wait_pct = 30;
    for (int i = 0; i < 4; i++) begin
      lat = int'($urandom_range(6, 1));
      v = (i == 0) ? V - 1 : int'($urandom_range(V - 1, 0));
      load(v, 1);
      wait_idle("rnd", 8000, 0);
    end
    chk("rnd_wr_bad", wr_bad, 0);
    chk("rd_stable", stab_bad, 0);
    wait_pct = 0;
    lat = 3;
    load(400, 1);
    tick(20);
    rst = 1;
    tick(2);
    rst = 0;
    exp_q.delete();
    wr_snap = wr_cnt;
    tick(20);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_no_writes", wr_cnt - wr_snap, 0);
    chk("rstmid_rd", 32'(mem_rd), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/vga_line_loader.md
Name: vga_line_loader

Overview:
- Responder/writer side of the VGA line-FIFO interface.
- Takes per-line load requests and frame clears from the VGA timing controller.
- Fetches one active line of 24-bit RGB pixels from the framebuffer through a pipelined read master, and writes the pixels into the display line FIFO.
- Sits between the memory controller and the display FIFO, in the iCLK domain.

Parameters:
- H_ACTIVE, 1024: pixels per line, also the number of words fetched per load.
- V_ACTIVE, 768: valid line numbers 0..V_ACTIVE-1.
- ADDR_W, 25: memory word-address width.
- FB_BASE, 0: word address of line 0, pixel 0.
- LINE_STRIDE, 1024: words between consecutive line starts.
- FIFO_DEPTH, 2048: line FIFO capacity in words.
- MAX_OUTST, 8: maximum number of accepted reads whose data has not yet returned.

Ports:
- iCLK  in  1  pixel clock; single clock domain.
- iRST  in  1  synchronous, active-high reset.
- iLOAD_REQ  in  1  load request; level, 2+ cycles wide; acted on at its rising edge.
- iLOAD_VLINE  in  13  line number to load; sampled at the iLOAD_REQ rising edge.
- iCLEAR  in  1  frame clear; level, acted on at its rising edge.
- oMEM_RD  out  1  read strobe.
- oMEM_ADDR  out  ADDR_W  read word address.
- iMEM_WAIT  in  1  waitrequest; a read is accepted in a cycle with oMEM_RD=1 and iMEM_WAIT=0.
- iMEM_RVALID  in  1  read data valid; data returns in order.
- iMEM_RDATA  in  24  {R,G,B} read data.
- oFIFO_WREQ  out  1  FIFO write enable.
- oFIFO_WDATA  out  24  FIFO write data.
- iFIFO_WUSEDW  in  12  FIFO fill level, write side.
- oFIFO_ACLR  out  1  FIFO clear.
- oBUSY  out  1  high whenever the state is not IDLE.
- oERR  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, state IDLE, pending flag cleared, outstanding count 0. Reset asserted mid-fetch aborts the fetch immediately; any data still in flight after reset is ignored.
- Edge detect: the previous-cycle values of iLOAD_REQ and iCLEAR are registered. An edge is recognised in the cycle where the input is 1 and the registered value is 0.
- Load edge with iLOAD_VLINE >= V_ACTIVE: request dropped, oERR set.
- Otherwise the request is latched into a one-deep pending slot. If the slot is already full, the new request overwrites it and oERR is set.
- oERR is cleared only by iRST or an iCLEAR edge.
- States: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - If pending: clear the slot, load base = FB_BASE + vline*LINE_STRIDE (truncated to ADDR_W), set pixel count to 0, go to ISSUE.
  - IDLE to ISSUE takes 1 cycle.
- ISSUE:
  - Assert oMEM_RD with oMEM_ADDR = base + pixel count, only while the credit condition holds.
  - Credit condition: outstanding < MAX_OUTST, and iFIFO_WUSEDW + outstanding + oFIFO_WREQ < FIFO_DEPTH-1.
  - When the credit condition fails, oMEM_RD drops to 0 in the same cycle. oMEM_ADDR holds.
  - Once asserted, oMEM_RD and oMEM_ADDR stay stable until the read is accepted.
  - On acceptance: increment pixel count and outstanding.
  - When the H_ACTIVE-th read is accepted, go to DRAIN.
- Data return:
  - Each iMEM_RVALID decrements outstanding.
  - oFIFO_WREQ=1 and oFIFO_WDATA=iMEM_RDATA are registered, so the FIFO write occurs 1 cycle after RVALID.
  - Acceptance and RVALID in the same cycle leave outstanding unchanged.
- DRAIN: when outstanding reaches 0 and no write is pending, go to IDLE. A pending request is then serviced on the next cycle.
- iCLEAR edge, in any state:
  - oFIFO_ACLR=1 for exactly 2 cycles.
  - oMEM_RD deasserted, pending slot cleared, go to FLUSH.
  - An unaccepted read is abandoned legally.
- FLUSH: returning data is discarded (oFIFO_WREQ held 0). When outstanding reaches 0, go to IDLE.
- Load edge during FLUSH: latched into the pending slot and serviced after FLUSH.
- Load edge and clear edge in the same cycle: the clear takes priority, and the load is still latched into the pending slot.
- Line fetch of vline=V_ACTIVE-1 with stride overflow: the address wraps modulo 2^ADDR_W; this is not an error.

Optional Feature:
- Macro LOADER_TEST_PATTERN_EN.
- Defined: the memory port is idle (oMEM_RD=0) and ISSUE writes the synthesized pixel {pix[7:0], vline[7:0], pix[7:0]^vline[7:0]} directly. Each write is gated by FIFO credit only. Latency is 1 cycle per pixel.
- Undefined: the memory path described above.

Decomposition:
- Shared header/package (extends vga_parameter.h):
  - H_ACTIVE and V_ACTIVE defaults.
  - State encodings IDLE=0, ISSUE=1, DRAIN=2, FLUSH=3.
  - Pixel width 24.
- One sub-module, vga_rd_tracker:
  - Outstanding counter and credit-condition logic.
  - Inputs: accept, rvalid, wusedw, wreq.
  - Outputs: can_issue, idle.

Test Plan:
- Load vline=5, zero-wait memory that returns addr[23:0] 2 cycles after accept:
  - 1024 FIFO writes with data 5*1024+k, k=0..1023.
  - oBUSY falls after the last write.
- iMEM_WAIT=1 for 3 cycles on read 10 -> oMEM_ADDR held at base+10 for 4 cycles; no duplicate or skipped writes.
- iFIFO_WUSEDW=2040 with 10-cycle read latency -> oMEM_RD gated; outstanding + used never exceeds 2047.
- iCLEAR edge mid-line with 6 reads outstanding -> oFIFO_ACLR high for 2 cycles; 0 FIFO writes for the returning data; state IDLE after the 6 RVALIDs.
- Load vline=800 -> no reads, oERR=1. Two loads while busy -> oERR=1, and the second load is serviced.
- With LOADER_TEST_PATTERN_EN, vline=3 -> pixel 7 = 0x070304; oMEM_RD stays 0.
